// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cacheline to fixed-burst memory adapter
`timescale 1ns/1ps

module cacheline_adapter #(
  parameter  int s_line  = 256,
  parameter  int s_beat  = 64,
  localparam int s_burst = s_line / s_beat
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_beat-1:0] burst_i,
  output logic [s_beat-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int cw  = $clog2(s_burst);
  localparam int off = $clog2(s_line / 8);
  localparam logic [cw-1:0] last_beat = cw'(s_burst - 1);
  // Line-aligned address: low bits select bytes within the line and are dropped.
  localparam logic [31:0] addr_mask = ~((32'd1 << off) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [cw-1:0]     cnt;
  logic [s_line-1:0] line_buf;
  logic [31:0]       addr_q;
  logic              read_q;
  logic              write_q;
  logic              resp_q;

  // Request acceptance, beat sequencing and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when the cache raises both requests at once.
          if (write_i) begin
            addr_q   <= address_i & addr_mask;
            line_buf <= line_i;
            cnt      <= '0;
            write_q  <= 1'b1;
            state    <= WRITE;
          end else if (read_i) begin
            addr_q   <= address_i & addr_mask;
            cnt      <= '0;
            read_q   <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf[s_beat*int'(cnt) +: s_beat] <= burst_i;
            cnt <= cnt + 1'b1;
            if (cnt == last_beat) begin
              read_q <= 1'b0;
              resp_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write beat is selected from registered buffer and counter only.
  always_comb begin
    burst_o = '0;
    if (state == WRITE) burst_o = line_buf[s_beat*int'(cnt) +: s_beat];
  end

  assign line_o    = line_buf;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
`timescale 1ns/1ps

module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cacheline_adapter #(.s_line(256), .s_beat(64)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic test_reset;
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
    repeat (2) @(negedge clk);
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {read_o, write_o, resp_o}); end
    checks++; if ({address_o, burst_o} !== 96'd0) begin failures++; $display("FAIL reset_addr_burst got=%h exp=0", {address_o, burst_o}); end
    checks++; if (line_o !== 256'd0) begin failures++; $display("FAIL reset_line got=%h exp=0", line_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL idle_after_reset got=%b exp=000", {read_o, write_o, resp_o}); end
  endtask

  task automatic test_read;
    logic [63:0]  b [4];
    logic [255:0] exp_line;
    for (int k = 0; k < 4; k++) b[k] = 64'hCAFEF00D_12345600 + 64'(k);
    exp_line = {b[3], b[2], b[1], b[0]};
    address_i = 32'h0000_1234; read_i = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin read_i = 0; address_i = 32'hFFFF_FFFF; end
      checks++; if ({read_o, write_o, resp_o} !== 3'b100) begin failures++; $display("FAIL read_ctl beat%0d got=%b exp=100", k, {read_o, write_o, resp_o}); end
      checks++; if (address_o !== 32'h0000_1220) begin failures++; $display("FAIL read_addr beat%0d got=%h exp=00001220", k, address_o); end
      burst_i = b[k]; resp_i = 1;
    end
    @(negedge clk);
    resp_i = 0;
    checks++; if ({read_o, write_o, resp_o} !== 3'b001) begin failures++; $display("FAIL read_done_ctl got=%b exp=001", {read_o, write_o, resp_o}); end
    checks++; if (line_o !== exp_line) begin failures++; $display("FAIL read_line got=%h exp=%h", line_o, exp_line); end
    @(negedge clk);
    checks++; if (resp_o !== 1'b0) begin failures++; $display("FAIL read_resp_pulse got=%b exp=0", resp_o); end
    checks++; if (line_o !== exp_line) begin failures++; $display("FAIL read_line_hold got=%h exp=%h", line_o, exp_line); end
  endtask

  task automatic test_write_stalls;
    logic [255:0] lw;
    logic [6:0]   pat;
    int           n;
    lw  = 256'h0123456789ABCDEF_FEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
    pat = 7'b1011001;
    n   = 0;
    line_i = lw; address_i = 32'h0000_2000; write_i = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin write_i = 0; line_i = '1; end
      checks++; if ({read_o, write_o, resp_o} !== 3'b010) begin failures++; $display("FAIL write_ctl step%0d got=%b exp=010", i, {read_o, write_o, resp_o}); end
      checks++; if (burst_o !== lw[64*n +: 64]) begin failures++; $display("FAIL write_beat step%0d got=%h exp=%h", i, burst_o, lw[64*n +: 64]); end
      resp_i = pat[i];
      if (pat[i]) n++;
    end
    @(negedge clk);
    resp_i = 0;
    checks++; if ({read_o, write_o, resp_o} !== 3'b001) begin failures++; $display("FAIL write_done_ctl got=%b exp=001", {read_o, write_o, resp_o}); end
    checks++; if (line_o !== lw) begin failures++; $display("FAIL write_line got=%h exp=%h", line_o, lw); end
    @(negedge clk);
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL write_idle_ctl got=%b exp=000", {read_o, write_o, resp_o}); end
  endtask

  task automatic test_simultaneous;
    logic [255:0] ls;
    ls = 256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7;
    line_i = ls; address_i = 32'h0000_ABCD; read_i = 1; write_i = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin read_i = 0; write_i = 0; end
      checks++; if ({read_o, write_o} !== 2'b01) begin failures++; $display("FAIL both_ctl beat%0d got=%b exp=01", k, {read_o, write_o}); end
      checks++; if (burst_o !== ls[64*k +: 64]) begin failures++; $display("FAIL both_beat beat%0d got=%h exp=%h", k, burst_o, ls[64*k +: 64]); end
      if (k == 0) begin
        checks++; if (address_o !== 32'h0000_ABC0) begin failures++; $display("FAIL both_addr got=%h exp=0000abc0", address_o); end
      end
      resp_i = 1;
    end
    @(negedge clk);
    resp_i = 0;
    checks++; if ({read_o, write_o, resp_o} !== 3'b001) begin failures++; $display("FAIL both_done got=%b exp=001", {read_o, write_o, resp_o}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    address_i = 32'h0000_0047; read_i = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) read_i = 0;
      burst_i = 64'h1111_2222_3333_4440 + 64'(k); resp_i = 1;
    end
    @(negedge clk);
    resp_i = 0;
    checks++; if (read_o !== 1'b1) begin failures++; $display("FAIL mid_read_active got=%b exp=1", read_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL async_reset_ctl got=%b exp=000", {read_o, write_o, resp_o}); end
    checks++; if ({address_o, burst_o} !== 96'd0) begin failures++; $display("FAIL async_reset_addr got=%h exp=0", {address_o, burst_o}); end
    checks++; if (line_o !== 256'd0) begin failures++; $display("FAIL async_reset_line got=%h exp=0", line_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL post_reset_idle cyc%0d got=%b exp=000", c, {read_o, write_o, resp_o}); end
      checks++; if (line_o !== 256'd0) begin failures++; $display("FAIL post_reset_line cyc%0d got=%h exp=0", c, line_o); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0]  c [4];
    logic [63:0]  d [4];
    logic [255:0] lc, ld;
    for (int k = 0; k < 4; k++) begin
      c[k] = 64'h5555_0000_0000_0010 + 64'(k);
      d[k] = 64'h7777_0000_0000_0020 + 64'(k);
    end
    lc = {c[3], c[2], c[1], c[0]};
    ld = {d[3], d[2], d[1], d[0]};
    address_i = 32'h0000_0100; read_i = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (read_o !== 1'b1) begin failures++; $display("FAIL b2b_first_read beat%0d got=%b exp=1", k, read_o); end
      burst_i = c[k]; resp_i = 1;
    end
    @(negedge clk);
    burst_i = 64'hDEAD_DEAD_DEAD_DEAD; resp_i = 1;
    checks++; if (resp_o !== 1'b1) begin failures++; $display("FAIL b2b_first_resp got=%b exp=1", resp_o); end
    checks++; if (line_o !== lc) begin failures++; $display("FAIL b2b_first_line got=%h exp=%h", line_o, lc); end
    @(negedge clk);
    burst_i = 64'hBEEF_BEEF_BEEF_BEEF; resp_i = 1;
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL b2b_idle_ctl got=%b exp=000", {read_o, write_o, resp_o}); end
    checks++; if (line_o !== lc) begin failures++; $display("FAIL b2b_stray_done got=%h exp=%h", line_o, lc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        read_i = 0;
        checks++; if (line_o !== lc) begin failures++; $display("FAIL b2b_stray_idle got=%h exp=%h", line_o, lc); end
      end
      checks++; if ({read_o, resp_o} !== 2'b10) begin failures++; $display("FAIL b2b_second_read beat%0d got=%b exp=10", k, {read_o, resp_o}); end
      burst_i = d[k]; resp_i = 1;
    end
    @(negedge clk);
    resp_i = 0;
    checks++; if ({read_o, resp_o} !== 2'b01) begin failures++; $display("FAIL b2b_second_resp got=%b exp=01", {read_o, resp_o}); end
    checks++; if (line_o !== ld) begin failures++; $display("FAIL b2b_second_line got=%h exp=%h", line_o, ld); end
    @(negedge clk);
    checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin failures++; $display("FAIL b2b_final_idle got=%b exp=000", {read_o, write_o, resp_o}); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_stalls;
    test_simultaneous;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
